// File: rtl/tpose_enc_pp.sv
// 8x8 block transposer with ping-pong storage: rows in, columns out,
// with LEVEL subtracted from output lane 0 (mod 2^W).
module tpose_enc_pp #(
  parameter int W     = 16,
  parameter int LEVEL = 2048
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a0_d,
  input  logic [W-1:0] a1_d,
  input  logic [W-1:0] a2_d,
  input  logic [W-1:0] a3_d,
  input  logic [W-1:0] a4_d,
  input  logic [W-1:0] a5_d,
  input  logic [W-1:0] a6_d,
  input  logic [W-1:0] a7_d,
  input  logic         a_v,
  output logic         a_r,
  output logic [W-1:0] b0_d,
  output logic [W-1:0] b1_d,
  output logic [W-1:0] b2_d,
  output logic [W-1:0] b3_d,
  output logic [W-1:0] b4_d,
  output logic [W-1:0] b5_d,
  output logic [W-1:0] b6_d,
  output logic [W-1:0] b7_d,
  output logic         b_v,
  input  logic         b_r
);

  localparam logic [W-1:0] LEVEL_W = W'(LEVEL);

  logic [W-1:0] a_lane [8];
  logic [W-1:0] b_col  [8];

  logic [W-1:0] bank_q [2][8][8];
  logic [W-1:0] bank_d [2][8][8];
  logic [1:0]   full_q, full_d;
  logic         wb_q, wb_d;
  logic         rb_q, rb_d;
  logic [2:0]   wr_q, wr_d;
  logic [2:0]   rc_q, rc_d;
  logic         a_acc, b_con;

  assign a_lane[0] = a0_d;
  assign a_lane[1] = a1_d;
  assign a_lane[2] = a2_d;
  assign a_lane[3] = a3_d;
  assign a_lane[4] = a4_d;
  assign a_lane[5] = a5_d;
  assign a_lane[6] = a6_d;
  assign a_lane[7] = a7_d;

  // NOTE: always_comb uses blocking assignments and gives every target a
  // default first, so later conditional updates cannot infer a latch.
  always_comb begin
    a_r    = !full_q[wb_q];
    b_v    = full_q[rb_q];
    a_acc  = a_v && a_r;
    b_con  = b_v && b_r;
    bank_d = bank_q;
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wr_d   = wr_q;
    rc_d   = rc_q;

    if (a_acc) begin
      for (int i = 0; i < 8; i++) begin
        bank_d[wb_q][wr_q][i] = a_lane[i];
      end
      wr_d = wr_q + 3'd1;
      if (wr_q == 3'd7) begin
        full_d[wb_q] = 1'b1;
        wb_d         = !wb_q;
      end
    end

    // The bank being released is never the one being filled, so the two
    // flag updates can both land in the same cycle.
    if (b_con) begin
      rc_d = rc_q + 3'd1;
      if (rc_q == 3'd7) begin
        full_d[rb_q] = 1'b0;
        rb_d         = !rb_q;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      b_col[j] = '0;
    end
    if (b_v) begin
      for (int j = 0; j < 8; j++) begin
        b_col[j] = bank_q[rb_q][j][rc_q];
      end
      b_col[0] = bank_q[rb_q][0][rc_q] - LEVEL_W;
    end
  end

  assign b0_d = b_col[0];
  assign b1_d = b_col[1];
  assign b2_d = b_col[2];
  assign b3_d = b_col[3];
  assign b4_d = b_col[4];
  assign b5_d = b_col[5];
  assign b6_d = b_col[6];
  assign b7_d = b_col[7];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wr_q   <= 3'd0;
      rc_q   <= 3'd0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wr_q   <= wr_d;
      rc_q   <= rc_d;
    end
  end

  // NOTE: sample storage has no reset; cleared full flags make any stale
  // contents unreachable, and outputs are forced to zero while b_v is low.
  always_ff @(posedge clock) begin
    bank_q <= bank_d;
  end

endmodule
